ir_move_transmitter: RTL and testbench

- Downstream of the main control FSM: serialises the 12-bit move_command onto the rover IR LED while transmit_ir is high.
- Frame format: SIRC-style pulse-width code, 40 kHz carrier, LSB first.
- Frames repeat back-to-back for as long as transmit is held, so a dropped frame is covered by the next one.
- The rover-side receiver decodes the same format.

---
 rtl/ir_move_transmitter.sv | 186 ++++++++++++++++++
 tb/tb_ir_move_transmitter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ir_move_transmitter.sv
// IR move-command transmitter: serialises a 12-bit command as a SIRC-style
// pulse-width frame (start burst, then per bit a gap and a 1- or 2-unit burst,
// LSB first), modulated onto a ~40 kHz carrier. Frames repeat back-to-back
// while transmit is held; each frame spans a fixed FRAME_UNITS period.
module ir_move_transmitter #(
    parameter int unsigned UNIT_CYCLES  = 16200,
    parameter int unsigned CARRIER_HALF = 338,
    parameter int unsigned START_UNITS  = 4,
    parameter int unsigned ONE_UNITS    = 2,
    parameter int unsigned ZERO_UNITS   = 1,
    parameter int unsigned GAP_UNITS    = 1,
    parameter int unsigned FRAME_UNITS  = 75,
    parameter int unsigned NUM_BITS     = 12
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                transmit,
    input  logic [NUM_BITS-1:0] move_command,
    output logic                ir_out,
    output logic                ir_envelope,
    output logic                busy,
    output logic                frame_done,
    output logic [7:0]          frame_count
);

    localparam int unsigned UNIT_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int unsigned CAR_W  = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
    localparam int unsigned BIT_W  = $clog2(NUM_BITS + 1);

    localparam logic [UNIT_W-1:0] UNIT_LAST  = UNIT_W'(UNIT_CYCLES - 1);
    localparam logic [CAR_W-1:0]  CAR_LAST   = CAR_W'(CARRIER_HALF - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST   = BIT_W'(NUM_BITS - 1);
    localparam logic [6:0]        FRAME_LAST = 7'(FRAME_UNITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StGap,
        StBit,
        StPad
    } state_e;

    state_e              state_q;
    logic [UNIT_W-1:0]   unit_cnt_q;
    logic [6:0]          frame_units_q;
    logic [6:0]          seg_units_q;
    logic [BIT_W-1:0]    bit_cnt_q;
    logic [NUM_BITS-1:0] shift_q;
    logic [CAR_W-1:0]    carrier_cnt_q;
    logic                carrier_q;

    logic       unit_tick;
    logic [6:0] seg_len;
    logic       seg_end;
    logic       frame_end;
    logic       start_frame;
    logic       burst_start;

    // Segment length in units and the timing events derived from the counters.
    always_comb begin
        seg_len = 7'd0;
        unique case (state_q)
            StStart: seg_len = 7'(START_UNITS);
            StGap:   seg_len = 7'(GAP_UNITS);
            StBit:   seg_len = shift_q[0] ? 7'(ONE_UNITS) : 7'(ZERO_UNITS);
            default: seg_len = 7'd0;
        endcase

        unit_tick   = (state_q != StIdle) && (unit_cnt_q == UNIT_LAST);
        seg_end     = unit_tick && (seg_units_q == (seg_len - 7'd1)) &&
                      ((state_q == StStart) || (state_q == StGap) || (state_q == StBit));
        frame_end   = (state_q == StPad) && unit_tick && (frame_units_q == FRAME_LAST);
        start_frame = transmit && ((state_q == StIdle) || frame_end);
        // Bursts begin on frame start and on every gap-to-bit transition.
        burst_start = start_frame || ((state_q == StGap) && seg_end);
    end

    // Unit timebase: cycle-in-unit, units since START entry, units in segment.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            unit_cnt_q    <= '0;
            frame_units_q <= '0;
            seg_units_q   <= '0;
        end else if (start_frame || frame_end || (state_q == StIdle)) begin
            unit_cnt_q    <= '0;
            frame_units_q <= '0;
            seg_units_q   <= '0;
        end else begin
            unit_cnt_q <= unit_tick ? '0 : unit_cnt_q + UNIT_W'(1);
            if (unit_tick) begin
                frame_units_q <= frame_units_q + 7'd1;
            end
            if (seg_end) begin
                seg_units_q <= '0;
            end else if (unit_tick) begin
                seg_units_q <= seg_units_q + 7'd1;
            end
        end
    end

    // Carrier generator, restarted in the high phase at every burst start.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            carrier_cnt_q <= '0;
            carrier_q     <= 1'b0;
        end else if (burst_start) begin
            carrier_cnt_q <= '0;
            carrier_q     <= 1'b1;
        end else if (carrier_cnt_q == CAR_LAST) begin
            carrier_cnt_q <= '0;
            carrier_q     <= ~carrier_q;
        end else begin
            carrier_cnt_q <= carrier_cnt_q + CAR_W'(1);
        end
    end

    // Frame sequencer with registered envelope, busy, frame_done and count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            ir_envelope <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            frame_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (transmit) begin
                        state_q     <= StStart;
                        shift_q     <= move_command;
                        bit_cnt_q   <= '0;
                        ir_envelope <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                StStart: begin
                    if (seg_end) begin
                        state_q     <= StGap;
                        ir_envelope <= 1'b0;
                    end
                end
                StGap: begin
                    if (seg_end) begin
                        state_q     <= StBit;
                        ir_envelope <= 1'b1;
                    end
                end
                StBit: begin
                    if (seg_end) begin
                        shift_q     <= shift_q >> 1;
                        bit_cnt_q   <= bit_cnt_q + BIT_W'(1);
                        ir_envelope <= 1'b0;
                        state_q     <= (bit_cnt_q == BIT_LAST) ? StPad : StGap;
                    end
                end
                StPad: begin
                    if (frame_end) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 8'd1;
                        if (transmit) begin
                            // Back-to-back frame: relatch on the same edge.
                            state_q     <= StStart;
                            shift_q     <= move_command;
                            bit_cnt_q   <= '0;
                            ir_envelope <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    ir_envelope <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    assign ir_out = ir_envelope & carrier_q;

endmodule

// File: tb/tb_ir_move_transmitter.sv
// Directed bench for ir_move_transmitter with UNIT_CYCLES=8, CARRIER_HALF=2.
module tb_ir_move_transmitter;

    localparam int FRAME = 600;  // 75 units * 8 cycles
    localparam int START = 32;   // 4 units
    localparam int GAP   = 8;
    localparam int ONE   = 16;
    localparam int ZERO  = 8;
    localparam int WFRAME = 82;  // wrap instance: 41 units * 2 cycles

    logic        clock = 1'b0;
    logic        reset;
    logic        transmit;
    logic [11:0] move_command;
    logic        ir_out, ir_envelope, busy, frame_done;
    logic [7:0]  frame_count;

    logic        transmit_w;
    logic        ir_out_w, ir_envelope_w, busy_w, frame_done_w;
    logic [7:0]  frame_count_w;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    ir_move_transmitter #(
        .UNIT_CYCLES (8),
        .CARRIER_HALF(2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .transmit    (transmit),
        .move_command(move_command),
        .ir_out      (ir_out),
        .ir_envelope (ir_envelope),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    // Shortened frame period so 256 frames take few cycles.
    ir_move_transmitter #(
        .UNIT_CYCLES (2),
        .CARRIER_HALF(2),
        .FRAME_UNITS (41)
    ) dut_wrap (
        .clock       (clock),
        .reset       (reset),
        .transmit    (transmit_w),
        .move_command(12'h5A5),
        .ir_out      (ir_out_w),
        .ir_envelope (ir_envelope_w),
        .busy        (busy_w),
        .frame_done  (frame_done_w),
        .frame_count (frame_count_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Expected {envelope, ir_out} at cycle k after the frame latch.
    function automatic logic [1:0] model(input logic [11:0] cmd, input int k);
        int t, s, len;
        logic env;
        env = 1'b0;
        s = 0;
        if (k < START) begin
            env = 1'b1;
        end else begin
            t = START;
            for (int b = 0; b < 12; b++) begin
                t += GAP;
                len = cmd[b] ? ONE : ZERO;
                if (k >= t && k < t + len) begin
                    env = 1'b1;
                    s = t;
                end
                t += len;
            end
        end
        return {env, env && ((((k - s) / 2) % 2) == 0)};
    endfunction

    // Called in cycle 0 of a frame; checks every cycle and ends in cycle 600.
    task automatic watch_frame(input string tag, input logic [11:0] cmd, input int drop_at,
                               input int chg_at, input logic [11:0] chg_cmd);
        int env_err, out_err, busy_err, done_err;
        logic [1:0] e;
        env_err = 0; out_err = 0; busy_err = 0; done_err = 0;
        for (int k = 0; k < FRAME; k++) begin
            e = model(cmd, k);
            if (ir_envelope !== e[1]) env_err++;
            if (ir_out !== e[0]) out_err++;
            if (busy !== 1'b1) busy_err++;
            if (k > 0 && frame_done !== 1'b0) done_err++;
            if (k == drop_at) transmit = 1'b0;
            if (k == chg_at) move_command = chg_cmd;
            step();
        end
        check({tag, "_env_errs"}, env_err, 0);
        check({tag, "_out_errs"}, out_err, 0);
        check({tag, "_busy_errs"}, busy_err, 0);
        check({tag, "_early_done"}, done_err, 0);
        check({tag, "_done_at_600"}, frame_done, 1);
    endtask

    initial begin
        int pulses, last, gap_err;
        reset = 1'b1;
        transmit = 1'b0;
        transmit_w = 1'b0;
        move_command = 12'h000;
        #2 reset = 1'b0;
        #1;
        check("rst_env", ir_envelope, 0);
        check("rst_out", ir_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_count", frame_count, 0);
        step();
        step();
        reset = 1'b1;
        step();

        // Single frame from a one-cycle pulse, command 00A.
        move_command = 12'h00A;
        transmit = 1'b1;
        check("t1_env_before", ir_envelope, 0);
        step();
        watch_frame("t1", 12'h00A, 0, -1, 12'h000);
        check("t1_busy_after", busy, 0);
        check("t1_count", frame_count, 1);
        step();
        check("t1_done_one_cycle", frame_done, 0);
        check("t1_idle_env", ir_envelope, 0);

        // Held transmit across three frames, command switched mid-frame.
        step();
        move_command = 12'h00A;
        transmit = 1'b1;
        step();
        watch_frame("t3f1", 12'h00A, -1, 100, 12'hF05);
        check("t3f1_count", frame_count, 2);
        check("t3f1_no_idle_env", ir_envelope, 1);
        check("t3f1_no_idle_busy", busy, 1);
        watch_frame("t3f2", 12'hF05, -1, -1, 12'hF05);
        check("t3f2_count", frame_count, 3);
        watch_frame("t3f3", 12'hF05, 300, -1, 12'hF05);
        check("t3f3_busy", busy, 0);
        check("t3f3_count", frame_count, 4);

        // Transmit dropped at cycle 50: full frame, then idle.
        step();
        transmit = 1'b1;
        step();
        watch_frame("t4", 12'hF05, 50, -1, 12'hF05);
        check("t4_busy", busy, 0);
        check("t4_count", frame_count, 5);
        pulses = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            if (frame_done === 1'b1) pulses++;
        end
        check("t4_extra_done", pulses, 0);

        // Reset at cycle 200 of a frame (inside bit 9's burst).
        move_command = 12'h00A;
        transmit = 1'b1;
        step();
        transmit = 1'b0;
        for (int c = 0; c < 200; c++) step();
        check("t5_env_pre", ir_envelope, 1);
        check("t5_out_pre", ir_out, 1);
        reset = 1'b0;
        #1;
        check("t5_async_env", ir_envelope, 0);
        check("t5_async_out", ir_out, 0);
        check("t5_async_busy", busy, 0);
        check("t5_async_count", frame_count, 0);
        step();
        step();
        reset = 1'b1;
        pulses = 0;
        for (int c = 0; c < 620; c++) begin
            step();
            if (frame_done !== 1'b0 || busy !== 1'b0) pulses++;
        end
        check("t5_no_done", pulses, 0);
        transmit = 1'b1;
        step();
        watch_frame("t5", 12'h00A, 0, -1, 12'h000);
        check("t5_count", frame_count, 1);
        check("t5_busy", busy, 0);

        // frame_count wrap over 256 back-to-back frames.
        transmit_w = 1'b1;
        pulses = 0;
        last = -1;
        gap_err = 0;
        for (int c = 0; c < 256 * WFRAME + 400 && pulses < 256; c++) begin
            step();
            if (frame_done_w === 1'b1) begin
                pulses++;
                if (last >= 0 && c - last != WFRAME) gap_err++;
                last = c;
                if (pulses == 255) check("t6_count_255", frame_count_w, 255);
                if (pulses == 256) check("t6_count_wrap", frame_count_w, 0);
            end
        end
        check("t6_pulses", pulses, 256);
        check("t6_spacing_errs", gap_err, 0);
        transmit_w = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
